// File: rtl/core_step_sequencer.sv
// Phase sequencer for the multi-phase RV32 core: one-cycle enable strobes per
// instruction phase, mul/div stall with timeout, run/step/halt, debug counters.
module core_step_sequencer #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             is_muldiv,
  input  logic             is_mem,
  input  logic             alu_complete,
  output logic             fetch_en,
  output logic             dec_en,
  output logic             alu_en,
  output logic             md_start,
  output logic             ram_en,
  output logic             reg_en,
  output logic             busy,
  output logic             halted,
  output logic             err_timeout,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int MD_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MD_WAIT = 3'd4,
    S_MEM     = 3'd5,
    S_WB      = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
  logic              err_q, err_d;
  logic              fetch_q, dec_q, alu_q, md_start_q, ram_q, reg_q;
  logic              busy_q, halted_q;
  logic [CNT_W-1:0]  cycle_q, retire_q;

  // Next-state, mul/div wait counter and timeout flag.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
        else             state_d = S_IDLE;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_muldiv) begin
          state_d  = S_MD_WAIT;
          md_cnt_d = {MD_W{1'b0}};
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MD_WAIT: begin
        // Completion beats the timeout when both land in the same cycle.
        if (alu_complete) begin
          state_d = S_WB;
        end else if (md_cnt_q == MD_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q + {{(MD_W-1){1'b0}}, 1'b1};
        end
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        if (halt_req)  state_d = S_HALT;
        else if (run)  state_d = S_FETCH;
        else           state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, strobes and counters; strobes are decoded from the next state so
  // they line up with the cycle the state register holds that phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      md_cnt_q   <= {MD_W{1'b0}};
      err_q      <= 1'b0;
      fetch_q    <= 1'b0;
      dec_q      <= 1'b0;
      alu_q      <= 1'b0;
      md_start_q <= 1'b0;
      ram_q      <= 1'b0;
      reg_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      cycle_q    <= {CNT_W{1'b0}};
      retire_q   <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      err_q      <= err_d;
      fetch_q    <= (state_d == S_FETCH);
      dec_q      <= (state_d == S_DECODE);
      alu_q      <= (state_d == S_EXEC) || (state_d == S_MD_WAIT);
      md_start_q <= (state_d == S_EXEC) && is_muldiv;
      ram_q      <= (state_d == S_MEM);
      reg_q      <= (state_d == S_WB);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q   <= (state_d == S_HALT);
      cycle_q    <= cycle_q + {{(CNT_W-1){1'b0}}, busy_q};
      if (state_q == S_WB) retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else                 retire_q <= retire_q;
    end
  end

  assign fetch_en    = fetch_q;
  assign dec_en      = dec_q;
  assign alu_en      = alu_q;
  assign md_start    = md_start_q;
  assign ram_en      = ram_q;
  assign reg_en      = reg_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err_timeout = err_q;
  assign state_o     = state_q;
  assign cycle_cnt   = cycle_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_core_step_sequencer.sv
// Bench for core_step_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an instruction-age model.
module tb_core_step_sequencer;

  localparam int MD_TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic        is_muldiv = 1'b0, is_mem = 1'b0, alu_complete = 1'b0;
  logic        fetch_en, dec_en, alu_en, md_start, ram_en, reg_en;
  logic        busy, halted, err_timeout;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt, retire_cnt;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  core_step_sequencer #(.MD_TIMEOUT(MD_TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
    .is_muldiv(is_muldiv), .is_mem(is_mem), .alu_complete(alu_complete),
    .fetch_en(fetch_en), .dec_en(dec_en), .alu_en(alu_en), .md_start(md_start),
    .ram_en(ram_en), .reg_en(reg_en), .busy(busy), .halted(halted),
    .err_timeout(err_timeout), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Model: an instruction is described by its age since FETCH and its kind
  // (0 alu, 1 mem, 2 mul/div); the expected phase follows from those.
  logic        m_active = 1'b0, m_halt = 1'b0, m_err = 1'b0, m_fin = 1'b0;
  int          m_age = 0, m_kind = 0, m_mdk = 0;
  logic [31:0] m_cyc = 32'd0, m_ret = 32'd0;

  function automatic int exp_st();
    if (m_halt)       return 7;
    if (!m_active)    return 0;
    if (m_age <= 2)   return m_age + 1;
    if (m_kind == 0)  return 6;
    if (m_kind == 1)  return (m_age == 3) ? 5 : 6;
    return m_fin ? 6 : 4;
  endfunction

  function automatic logic [11:0] exp_vec();
    int st;
    logic [2:0] s3;
    st = exp_st();
    s3 = 3'(st);
    return {st == 1, st == 2, (st == 3) || (st == 4), (st == 3) && (m_kind == 2),
            st == 5, st == 6, (st != 0) && (st != 7), st == 7, m_err, s3};
  endfunction

  always @(posedge clk) begin
    int st;
    st = exp_st();
    if (rst) begin
      m_active <= 1'b0; m_halt <= 1'b0; m_err <= 1'b0; m_fin <= 1'b0;
      m_age <= 0; m_kind <= 0; m_mdk <= 0; m_cyc <= 32'd0; m_ret <= 32'd0;
    end else begin
      if (st != 0 && st != 7) m_cyc <= m_cyc + 32'd1;
      case (st)
        0: if (run || step) begin
          m_active <= 1'b1; m_age <= 0; m_fin <= 1'b0; m_mdk <= 0;
        end
        6: begin
          m_ret <= m_ret + 32'd1;
          if (halt_req) begin m_halt <= 1'b1; m_active <= 1'b0; end
          else if (run) begin m_age <= 0; m_fin <= 1'b0; m_mdk <= 0; end
          else m_active <= 1'b0;
        end
        4: begin
          m_age <= m_age + 1;
          if (alu_complete) m_fin <= 1'b1;
          else if (m_mdk + 1 == MD_TO) begin
            m_halt <= 1'b1; m_err <= 1'b1; m_active <= 1'b0;
          end else m_mdk <= m_mdk + 1;
        end
        7: ;
        default: begin
          if (m_age == 1) m_kind <= is_muldiv ? 2 : (is_mem ? 1 : 0);
          m_age <= m_age + 1;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", {fetch_en, dec_en, alu_en, md_start, ram_en, reg_en,
                      busy, halted, err_timeout, state_o}, exp_vec());
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("retire_cnt", retire_cnt, m_ret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; alu_complete = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles, then one single-step ALU instruction.
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_state", state_o, 3'd0);
    chk("rst_cnt", {cycle_cnt, retire_cnt}, 64'd0);
    chk("rst_strobes", {fetch_en, dec_en, alu_en, md_start, ram_en, reg_en, busy, halted, err_timeout}, 9'd0);
    rst = 1'b0; step = 1'b1;
    tick(); step = 1'b0;
    chk("step_fetch", fetch_en, 1'b1);
    repeat (4) tick();
    chk("step_state", state_o, 3'd0);
    chk("step_retire", retire_cnt, 32'd1);
    chk("step_cycles", cycle_cnt, 32'd4);

    // Three back-to-back loads/stores.
    do_reset();
    is_mem = 1'b1; run = 1'b1;
    repeat (15) tick();
    chk("mem_wb", reg_en, 1'b1);
    run = 1'b0;
    tick();
    chk("mem_idle", state_o, 3'd0);
    chk("mem_retire", retire_cnt, 32'd3);
    chk("mem_cycles", cycle_cnt, 32'd15);

    // Mul/div completing on the 5th wait cycle.
    do_reset();
    is_mem = 1'b0; is_muldiv = 1'b1; run = 1'b1;
    repeat (3) tick();
    chk("md_start", md_start, 1'b1);
    run = 1'b0;
    repeat (5) tick();
    chk("md_wait5", state_o, 3'd4);
    alu_complete = 1'b1;
    tick(); alu_complete = 1'b0;
    chk("md_wb", state_o, 3'd6);
    chk("md_noerr", err_timeout, 1'b0);
    tick();
    chk("md_retire", retire_cnt, 32'd1);
    chk("md_cycles", cycle_cnt, 32'd9);

    // Timeout after MD_TO wait cycles, then halt is sticky until reset.
    do_reset();
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    repeat (MD_TO) tick();
    chk("to_last_wait", state_o, 3'd4);
    tick();
    chk("to_halt", {state_o, err_timeout, halted}, {3'd7, 1'b1, 1'b1});
    run = 1'b1; step = 1'b1;
    repeat (4) tick();
    chk("to_sticky", state_o, 3'd7);
    do_reset();
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    repeat (MD_TO) tick();
    alu_complete = 1'b1;
    tick(); alu_complete = 1'b0;
    chk("to_edge_wb", {state_o, err_timeout}, {3'd6, 1'b0});
    tick();
    chk("to_edge_idle", state_o, 3'd0);

    // Halt request raised during EXEC still retires the instruction.
    do_reset();
    is_muldiv = 1'b0; run = 1'b1;
    repeat (3) tick();
    halt_req = 1'b1;
    tick();
    chk("halt_wb_reg", reg_en, 1'b1);
    tick();
    chk("halt_state", {state_o, halted}, {3'd7, 1'b1});
    chk("halt_retire", retire_cnt, 32'd1);

    // Reset arriving in MEM.
    do_reset();
    is_mem = 1'b1; run = 1'b1;
    repeat (4) tick();
    chk("mid_mem", state_o, 3'd5);
    rst = 1'b1;
    tick();
    chk("mid_rst_all", {fetch_en, dec_en, alu_en, md_start, ram_en, reg_en, busy, halted, err_timeout, state_o}, 12'd0);
    chk("mid_rst_cnt", {cycle_cnt, retire_cnt}, 64'd0);
    rst = 1'b0; run = 1'b0;
    tick();
    chk("mid_rst_noram", ram_en, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int st, k;
      st = exp_st();
      rst = (st == 7) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 49) == 0);
      alu_complete = ($urandom_range(0, 5) == 0);
      if (st == 0 || st == 1) begin
        k = $urandom_range(0, 2);
        is_muldiv = (k == 2);
        is_mem = (k == 1) || ((k == 2) && ($urandom_range(0, 1) == 0));
      end
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
